// File: rtl/manchester_encoder.sv
// rtl/manchester_encoder.sv - Manchester line transmitter with bit FIFO and inter-frame gap.
// Optional training preamble before each frame: MANCHESTER_ENCODER_PREAMBLE_EN.
module manchester_encoder #(
  parameter int HALF_PERIOD   = 8,
  parameter int DEPTH         = 4,
  parameter int GAP_BITS      = 2,
  parameter int PREAMBLE_BITS = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_data,
  input  logic                       in_clk,
  output logic                       out,
  output logic                       out_busy,
  output logic                       out_overflow,
  output logic [$clog2(DEPTH):0]     out_fill
);

  localparam int AW      = $clog2(DEPTH);
  localparam int GAP_LEN = GAP_BITS * 2 * HALF_PERIOD;
  localparam int CW      = $clog2(GAP_LEN);

  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_LEN - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FIRST  = 3'd1;
  localparam logic [2:0] S_SECOND = 3'd2;
  localparam logic [2:0] S_GAP    = 3'd3;
`ifdef MANCHESTER_ENCODER_PREAMBLE_EN
  localparam logic [2:0] S_PRE    = 3'd4;
  localparam int         PW       = $clog2(2 * PREAMBLE_BITS);
  localparam logic [PW-1:0] PRE_LAST = PW'(2 * PREAMBLE_BITS - 1);
`endif

  if (HALF_PERIOD < 1 || HALF_PERIOD > 255 || DEPTH < 2 || DEPTH > 16 ||
      (DEPTH & (DEPTH - 1)) != 0 || GAP_BITS < 1 || GAP_BITS > 15 ||
      PREAMBLE_BITS < 1) begin : g_bad_param
    $error("manchester_encoder: parameter out of range");
  end

  logic [DEPTH-1:0] r_mem;
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [2:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_out;
  logic             r_overflow;
`ifdef MANCHESTER_ENCODER_PREAMBLE_EN
  logic [PW-1:0]    r_pre_idx;
`endif

  logic [AW:0] w_fill;
  logic        w_empty;
  logic        w_full;
  logic        w_head;
  logic        w_half_done;
  logic        w_pop;
  logic        w_push;
  logic        w_drop;

  assign w_fill      = r_wr_ptr - r_rd_ptr;
  assign w_empty     = (w_fill == '0);
  assign w_full      = (w_fill == FULL_CNT);
  assign w_head      = r_mem[r_rd_ptr[AW-1:0]];
  assign w_half_done = (r_cnt == HALF_LAST);

  // A pop frees a slot in the same edge, so a full FIFO still accepts a write then.
  always_comb begin
    w_pop = 1'b0;
    case (r_state)
`ifdef MANCHESTER_ENCODER_PREAMBLE_EN
      S_PRE:    w_pop = w_half_done && (r_pre_idx == PRE_LAST);
`else
      S_IDLE:   w_pop = !w_empty;
`endif
      S_SECOND: w_pop = w_half_done && !w_empty;
      default:  w_pop = 1'b0;
    endcase
  end

  assign w_push = in_clk && (!w_full || w_pop);
  assign w_drop = in_clk && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_out      <= 1'b0;
      r_overflow <= 1'b0;
`ifdef MANCHESTER_ENCODER_PREAMBLE_EN
      r_pre_idx  <= '0;
`endif
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW + 1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW + 1)'(1);
      if (w_drop) r_overflow <= 1'b1;

      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          r_out <= 1'b0;
          if (!w_empty) begin
`ifdef MANCHESTER_ENCODER_PREAMBLE_EN
            r_state   <= S_PRE;
            r_pre_idx <= '0;
            r_out     <= 1'b1;
`else
            r_state <= S_FIRST;
            r_out   <= ~w_head;
`endif
          end
        end

        S_FIRST: begin
          if (w_half_done) begin
            r_state <= S_SECOND;
            r_cnt   <= '0;
            r_out   <= ~r_out;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        // Back-to-back bits stay in the frame; an empty FIFO closes it.
        S_SECOND: begin
          if (w_half_done) begin
            r_cnt <= '0;
            if (!w_empty) begin
              r_state <= S_FIRST;
              r_out   <= ~w_head;
            end else begin
              r_state <= S_GAP;
              r_out   <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_GAP: begin
          r_out <= 1'b0;
          if (r_cnt == GAP_LAST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

`ifdef MANCHESTER_ENCODER_PREAMBLE_EN
        // Preamble '0' bits are a plain 1/0 alternation of half periods.
        S_PRE: begin
          if (w_half_done) begin
            r_cnt <= '0;
            if (r_pre_idx == PRE_LAST) begin
              r_state <= S_FIRST;
              r_out   <= ~w_head;
            end else begin
              r_pre_idx <= r_pre_idx + PW'(1);
              r_out     <= ~r_out;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
`endif

        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_out   <= 1'b0;
        end
      endcase
    end
  end

  assign out          = r_out;
  assign out_busy     = (r_state != S_IDLE);
  assign out_overflow = r_overflow;
  assign out_fill     = w_fill;

endmodule

// File: tb/tb_manchester_encoder.sv
// tb/tb_manchester_encoder.sv - self-checking bench for manchester_encoder.
// Build with MANCHESTER_ENCODER_PREAMBLE_EN to exercise the preamble variant.
module tb_manchester_encoder;

  localparam int HP    = 4;
  localparam int DEPTH = 4;
  localparam int GAPB  = 2;
  localparam int PREB  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_data = 1'b0;
  logic       in_clk = 1'b0;
  logic       dut_out;
  logic       dut_busy;
  logic       dut_ovf;
  logic [2:0] dut_fill;

  manchester_encoder #(
    .HALF_PERIOD(HP), .DEPTH(DEPTH), .GAP_BITS(GAPB), .PREAMBLE_BITS(PREB)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_clk(in_clk),
    .out(dut_out), .out_busy(dut_busy), .out_overflow(dut_ovf), .out_fill(dut_fill)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  typedef struct {
    logic en;
    logic d;
    logic exp_out;
    logic exp_busy;
    logic exp_ovf;
    int   exp_fill;
  } vec_t;

  vec_t vecs[];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic o, input logic b, input logic v, input int f);
    chk({nm, " out"}, 32'(dut_out), 32'(o));
    chk({nm, " busy"}, 32'(dut_busy), 32'(b));
    chk({nm, " overflow"}, 32'(dut_ovf), 32'(v));
    chk({nm, " fill"}, 32'(dut_fill), 32'(f));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_clk  = 1'($urandom);
      in_data = 1'($urandom);
      @(negedge clk);
      chk_all($sformatf("reset c%0d", i), 1'b0, 1'b0, 1'b0, 0);
    end
    rst = 1'b0;
    in_clk = 1'b0;
    @(negedge clk);
    chk_all("reset release", 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic new_table(input int n);
    vecs = new[n];
    for (int i = 0; i < n; i++) begin
      vecs[i].en = 1'b0; vecs[i].d = 1'b0; vecs[i].exp_out = 1'b0;
      vecs[i].exp_busy = 1'b0; vecs[i].exp_ovf = 1'b0; vecs[i].exp_fill = 0;
    end
  endtask

  task automatic set_out(input int start, input string pat);
    for (int i = 0; i < pat.len(); i++) vecs[start + i].exp_out = (pat.getc(i) == "1");
  endtask

  task automatic set_busy(input int a, input int b);
    for (int i = a; i <= b; i++) vecs[i].exp_busy = 1'b1;
  endtask

  task automatic set_ovf(input int a, input int b);
    for (int i = a; i <= b; i++) vecs[i].exp_ovf = 1'b1;
  endtask

  task automatic set_fill(input int a, input int b, input int v);
    for (int i = a; i <= b; i++) vecs[i].exp_fill = v;
  endtask

  task automatic strobe(input int c, input logic d);
    vecs[c].en = 1'b1;
    vecs[c].d  = d;
  endtask

  task automatic run_table(input string nm);
    for (int k = 0; k < vecs.size(); k++) begin
      chk_all($sformatf("%s c%0d", nm, k), vecs[k].exp_out, vecs[k].exp_busy,
              vecs[k].exp_ovf, vecs[k].exp_fill);
      in_clk  = vecs[k].en;
      in_data = vecs[k].d;
      @(negedge clk);
    end
    in_clk = 1'b0;
  endtask

  // Reference model: the line is a queue of future levels built from the coding rules.
  bit m_fifo[$];
  bit m_line[$];
  int m_mode;   // 0 idle, 1 data bit, 2 gap, 3 preamble
  bit m_out, m_busy, m_ovf;

  task automatic m_send_bit(input bit b);
    repeat (HP) m_line.push_back(~b);
    repeat (HP) m_line.push_back(b);
  endtask

  task automatic m_clear();
    m_fifo.delete();
    m_line.delete();
    m_mode = 0; m_out = 0; m_busy = 0; m_ovf = 0;
  endtask

  task automatic m_step(input bit r, input bit en, input bit d);
    if (r) begin
      m_clear();
      return;
    end
    if (m_line.size() == 0) begin
      case (m_mode)
        0: if (m_fifo.size() > 0) begin
`ifdef MANCHESTER_ENCODER_PREAMBLE_EN
             for (int i = 0; i < PREB; i++) m_send_bit(1'b0);
             m_mode = 3;
`else
             m_send_bit(m_fifo.pop_front());
             m_mode = 1;
`endif
           end
        1: if (m_fifo.size() > 0) m_send_bit(m_fifo.pop_front());
           else begin
             repeat (GAPB * 2 * HP) m_line.push_back(1'b0);
             m_mode = 2;
           end
        2: m_mode = 0;
        default: begin
          m_send_bit(m_fifo.pop_front());
          m_mode = 1;
        end
      endcase
    end
    if (en) begin
      if (m_fifo.size() < DEPTH) m_fifo.push_back(d);
      else m_ovf = 1;
    end
    m_out  = (m_line.size() > 0) ? m_line.pop_front() : 1'b0;
    m_busy = (m_mode != 0);
  endtask

  initial begin
    do_reset();

`ifndef MANCHESTER_ENCODER_PREAMBLE_EN
    // Single '1' bit: one frame then gap.
    new_table(28);
    strobe(0, 1'b1);
    set_out(6, "1111");
    set_busy(2, 25);
    set_fill(1, 1, 1);
    run_table("single");

    // Four contiguous bits 1,0,1,1.
    do_reset();
    new_table(52);
    strobe(0, 1'b1); strobe(1, 1'b0); strobe(2, 1'b1); strobe(3, 1'b1);
    set_out(2, "00001111111100000000111100001111");
    set_busy(2, 49);
    set_fill(1, 2, 1); set_fill(3, 3, 2); set_fill(4, 9, 3);
    set_fill(10, 17, 2); set_fill(18, 25, 1);
    run_table("burst4");

    // Eight strobes into a depth-4 FIFO: three bits dropped.
    do_reset();
    new_table(60);
    for (int i = 0; i < 8; i++) strobe(i, (i % 2) == 0);
    set_out(2, "0000111111110000000011111111000000001111");
    set_busy(2, 57);
    set_ovf(6, 59);
    set_fill(1, 2, 1); set_fill(3, 3, 2); set_fill(4, 4, 3); set_fill(5, 9, 4);
    set_fill(10, 17, 3); set_fill(18, 25, 2); set_fill(26, 33, 1);
    run_table("overflow");

    // Reset in the middle of a first half, then a fresh bit.
    do_reset();
    in_clk = 1'b1; in_data = 1'b0;
    @(negedge clk);
    in_clk = 1'b0;
    @(negedge clk);
    chk_all("midreset c2", 1'b1, 1'b1, 1'b0, 0);
    @(negedge clk);
    @(negedge clk);
    chk_all("midreset c4", 1'b1, 1'b1, 1'b0, 0);
    rst = 1'b1;
    @(negedge clk);
    chk_all("midreset c5", 1'b0, 1'b0, 1'b0, 0);
    rst = 1'b0;
    @(negedge clk);
    in_clk = 1'b1; in_data = 1'b0;
    @(negedge clk);
    in_clk = 1'b0;
    chk_all("midreset c7", 1'b0, 1'b0, 1'b0, 1);
    @(negedge clk);
    chk_all("midreset c8", 1'b1, 1'b1, 1'b0, 0);
`else
    // Preamble of two '0' bits ahead of a single '1'.
    new_table(44);
    strobe(0, 1'b1);
    set_out(2, "1111000011110000");
    set_out(18, "00001111");
    set_busy(2, 41);
    set_fill(1, 17, 1);
    run_table("preamble");
`endif

    // Random traffic against the reference model.
    do_reset();
    m_clear();
    for (int c = 0; c < 3000; c++) begin
      bit r, en, d;
      chk_all($sformatf("rand c%0d", c), m_out, m_busy, m_ovf, m_fifo.size());
      r  = ($urandom_range(0, 299) == 0);
      en = ($urandom_range(0, 2) == 0);
      d  = 1'($urandom);
      rst = r; in_clk = en; in_data = d;
      m_step(r, en, d);
      @(negedge clk);
    end
    rst = 1'b0; in_clk = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
